pwl_op_sched: RTL and testbench

- Sample-rate sequencer for the shared multichannel PWL ALU (phase, period, amp, sweep, pwm_offset and slope state for NUM_CHANNELS voices).
- Once per sample period it issues a fixed micro-op sequence per channel over a valid/ready handshake.
- Grants the host register interface access to the shared channel state only at safe points: while idle or between channels.
- Flags sample overruns.

---
 rtl/pwl_sched_pkg.sv | 19 +
 rtl/pwl_sample_div.sv | 35 +++
 rtl/pwl_op_sched.sv | 136 +++++++++++++
 tb/tb_pwl_op_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pwl_sched_pkg.sv
// Shared types for the PWL ALU sample sequencer: micro-op codes and FSM states.
package pwl_sched_pkg;

  localparam int NUM_CHANNELS = 4;

  typedef enum logic [1:0] {
    OP_PHASE = 2'd0,
    OP_SWEEP = 2'd1,
    OP_OUT   = 2'd2,
    OP_DONE  = 2'd3
  } op_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOST = 2'd2
  } state_e;

endpackage

// File: rtl/pwl_sample_div.sv
// Sample-period divider: tick is raised combinationally in the cycle the counter is 0.
// Counter reloads with sample_div on tick, so ticks are sample_div+1 cycles apart.
module pwl_sample_div
  import pwl_sched_pkg::*;
#(
  parameter int DIV_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [DIV_BITS-1:0] sample_div,
  output logic                tick
);

  logic [DIV_BITS-1:0] div_cnt_q;
  logic [DIV_BITS-1:0] div_cnt_d;

  assign tick = enable && (div_cnt_q == '0);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (enable) begin
      div_cnt_d = tick ? sample_div : (div_cnt_q - DIV_BITS'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/pwl_op_sched.sv
// Per-sample micro-op sequencer for the shared PWL ALU, with host access
// granted only while idle or in a one-cycle slot between channels.
module pwl_op_sched
  import pwl_sched_pkg::*;
#(
  parameter int NUM_CHANNELS = pwl_sched_pkg::NUM_CHANNELS,
  parameter int CH_BITS      = 2,
  parameter int DIV_BITS     = 8,
  parameter int FRAME_BITS   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [DIV_BITS-1:0] sample_div,
  input  logic [2:0]          sweep_div,
  output logic                op_valid,
  input  logic                op_ready,
  output logic [1:0]          op_code,
  output logic [CH_BITS-1:0]  op_ch,
  input  logic                host_req,
  output logic                host_gnt,
  output logic                busy,
  output logic                sample_strobe,
  output logic                overrun,
  input  logic                overrun_clr
);

  localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(NUM_CHANNELS - 1);

  state_e                state_q;
  op_code_e              op_code_q;
  logic [CH_BITS-1:0]    op_ch_q;
  logic                  op_valid_q;
  logic                  busy_q;
  logic                  sample_strobe_q;
  logic                  overrun_q;
  logic                  sweep_pending_q;
  logic [FRAME_BITS-1:0] frame_cnt_q;
  logic [FRAME_BITS-1:0] sweep_mask;
  logic                  tick;

  pwl_sample_div #(
    .DIV_BITS(DIV_BITS)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .sample_div(sample_div),
    .tick      (tick)
  );

  assign sweep_mask = (FRAME_BITS'(1) << sweep_div) - FRAME_BITS'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      op_code_q       <= OP_PHASE;
      op_ch_q         <= '0;
      op_valid_q      <= 1'b0;
      busy_q          <= 1'b0;
      sample_strobe_q <= 1'b0;
      overrun_q       <= 1'b0;
      sweep_pending_q <= 1'b0;
      frame_cnt_q     <= '0;
    end else begin
      sample_strobe_q <= 1'b0;

      // A tick landing mid-sequence is dropped; setting beats clearing.
      if (tick && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        overrun_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            sweep_pending_q <= (frame_cnt_q & sweep_mask) == '0;
            frame_cnt_q     <= frame_cnt_q + FRAME_BITS'(1);
            op_ch_q         <= '0;
            op_code_q       <= OP_PHASE;
            op_valid_q      <= 1'b1;
            busy_q          <= 1'b1;
            state_q         <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (op_ready) begin
            case (op_code_q)
              OP_PHASE: op_code_q <= sweep_pending_q ? OP_SWEEP : OP_OUT;
              OP_SWEEP: op_code_q <= OP_OUT;
              OP_OUT: begin
                if (op_ch_q == LAST_CH) begin
                  op_code_q <= OP_DONE;
                  op_ch_q   <= '0;
                end else if (host_req) begin
                  op_valid_q <= 1'b0;
                  state_q    <= ST_HOST;
                end else begin
                  op_code_q <= OP_PHASE;
                  op_ch_q   <= op_ch_q + CH_BITS'(1);
                end
              end
              OP_DONE: begin
                op_valid_q      <= 1'b0;
                busy_q          <= 1'b0;
                sample_strobe_q <= 1'b1;
                state_q         <= ST_IDLE;
              end
              default: op_code_q <= OP_PHASE;
            endcase
          end
        end
        ST_HOST: begin
          op_code_q  <= OP_PHASE;
          op_ch_q    <= op_ch_q + CH_BITS'(1);
          op_valid_q <= 1'b1;
          state_q    <= ST_RUN;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Idle grant follows host_req directly so the host sees it the same cycle.
  assign host_gnt = !reset && ((state_q == ST_HOST) ||
                               ((state_q == ST_IDLE) && host_req && !tick));

  assign op_valid      = op_valid_q;
  assign op_code       = op_code_q;
  assign op_ch         = op_ch_q;
  assign busy          = busy_q;
  assign sample_strobe = sample_strobe_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_pwl_op_sched.sv
// Scoreboard bench for pwl_op_sched: a cycle model predicts every micro-op,
// grant, strobe and overrun flag; accepted ops are popped from a queue and compared.
module tb_pwl_op_sched;

  localparam int NCH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [7:0] sample_div = 8'd31;
  logic [2:0] sweep_div = 3'd0;
  logic       op_ready = 1'b1;
  logic       host_req = 1'b0;
  logic       overrun_clr = 1'b0;
  logic       op_valid;
  logic [1:0] op_code;
  logic [1:0] op_ch;
  logic       host_gnt;
  logic       busy;
  logic       sample_strobe;
  logic       overrun;

  pwl_op_sched dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_div   (sample_div),
    .sweep_div    (sweep_div),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_code      (op_code),
    .op_ch        (op_ch),
    .host_req     (host_req),
    .host_gnt     (host_gnt),
    .busy         (busy),
    .sample_strobe(sample_strobe),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model state
  logic [3:0] exp_q[$];
  logic       host_m, strobe_m, ovr_m, sweep_m, held_vld;
  logic [3:0] held_op;
  logic [7:0] frame_m, cnt_m;
  int         ops_m;

  task automatic model_reset();
    exp_q.delete();
    host_m = 0; strobe_m = 0; ovr_m = 0; sweep_m = 0; held_vld = 0; held_op = '0;
    frame_m = 0; cnt_m = 0; ops_m = 0;
  endtask

  task automatic push_sample();
    int period;
    period = 1 << sweep_div;
    sweep_m = (int'(frame_m) % period) == 0;
    frame_m = frame_m + 8'd1;
    for (int c = 0; c < NCH; c++) begin
      exp_q.push_back({2'd0, 2'(c)});
      if (sweep_m) exp_q.push_back({2'd1, 2'(c)});
      exp_q.push_back({2'd2, 2'(c)});
    end
    exp_q.push_back({2'd3, 2'd0});
    ops_m = 0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_valid"}, op_valid, 0);
    chk({pfx, "_code"}, op_code, 0);
    chk({pfx, "_ch"}, op_ch, 0);
    chk({pfx, "_gnt"}, host_gnt, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_strobe"}, sample_strobe, 0);
    chk({pfx, "_overrun"}, overrun, 0);
  endtask

  // Inputs are applied at posedge+1; this evaluates the current cycle and
  // returns at posedge+1 of the next one.
  task automatic run_cycle();
    logic idle, tick, host_n, strobe_n, ovr_n;
    logic [3:0] got, e;
    #2;
    if (reset) begin
      check_reset_outputs("rst");
      model_reset();
    end else begin
      idle = (exp_q.size() == 0);
      tick = enable && (cnt_m == 8'd0);
      chk("op_valid", op_valid, !idle && !host_m);
      chk("host_gnt", host_gnt, host_m || (idle && host_req && !tick));
      chk("busy", busy, !idle);
      chk("strobe", sample_strobe, strobe_m);
      chk("overrun", overrun, ovr_m);
      got = {op_code, op_ch};
      if (held_vld && op_valid) chk("hold", got, held_op);
      held_vld = op_valid && !op_ready;
      held_op = got;
      host_n = 0;
      strobe_n = 0;
      if (op_valid && op_ready) begin
        chk("q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("op", got, e);
          ops_m++;
          if (e[3:2] == 2'd2 && e[1:0] != 2'(NCH - 1) && host_req) host_n = 1;
          if (e[3:2] == 2'd3) begin
            strobe_n = 1;
            chk("op_count", ops_m, sweep_m ? 13 : 9);
          end
        end
      end
      ovr_n = ovr_m;
      if (tick && !idle) ovr_n = 1;
      else if (overrun_clr) ovr_n = 0;
      if (tick && idle) push_sample();
      if (enable) cnt_m = (cnt_m == 8'd0) ? sample_div : cnt_m - 8'd1;
      host_m = host_n;
      strobe_m = strobe_n;
      ovr_m = ovr_n;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  initial begin
    int n;
    model_reset();
    #1;
    run_n(3);

    // Basic sequence, sweep on every sample
    reset = 0;
    run_n(100);

    // Sweep only on every 4th frame
    sweep_div = 3'd2;
    run_n(420);

    // Backpressure: ready low two cycles of every three
    sweep_div = 3'd0;
    sample_div = 8'd63;
    for (int i = 0; i < 200; i++) begin
      op_ready = (i % 3) == 2;
      run_cycle();
    end
    op_ready = 1;

    // Host constantly requesting
    sample_div = 8'd31;
    run_n(70);
    host_req = 1;
    run_n(100);
    host_req = 0;

    // Overrun: period far too short for a full sequence
    sample_div = 8'd5;
    run_n(40);
    chk("ovr_seen", overrun, 1);
    overrun_clr = 1;
    run_cycle();
    overrun_clr = 0;
    run_n(40);
    chk("ovr_reset", overrun, 1);
    sample_div = 8'd31;
    run_n(40);
    overrun_clr = 1;
    run_cycle();
    overrun_clr = 0;
    run_n(40);

    // Reset while SWEEP on channel 1 is presented
    n = 0;
    while (!(op_valid && op_code == 2'd1 && op_ch == 2'd1) && n < 400) begin
      run_cycle();
      n++;
    end
    chk("find_sweep1", n < 400, 1);
    reset = 1;
    #1;
    check_reset_outputs("mid_rst");
    model_reset();
    #1;
    run_n(2);
    reset = 0;
    run_n(80);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
